// File: rtl/bus_change_monitor.sv
// bus_change_monitor: settle-filtered multi-channel bus change events on a round-robin valid/ready stream; optional timestamps via BUS_CHANGE_MONITOR_TIMESTAMP_EN
module bus_change_monitor #(
  parameter int BUS_WIDTH     = 8,
  parameter int NUM_CH        = 4,
  parameter int SETTLE_CYCLES = 16,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CH*BUS_WIDTH-1:0] i_bus,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [CH_W-1:0]             o_ch,
  output logic [BUS_WIDTH-1:0]        o_value,
  output logic [NUM_CH-1:0]           o_pending,
  output logic [NUM_CH-1:0]           o_overrun,
  input  logic                        i_clear_overrun
`ifdef BUS_CHANGE_MONITOR_TIMESTAMP_EN
  ,
  output logic [15:0]                 o_timestamp
`endif
);
  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {PRIME, STABLE, SETTLING} state_t;

  logic [NUM_CH-1:0]           acc_v;
  logic [NUM_CH*BUS_WIDTH-1:0] val_v;
  logic [BUS_WIDTH-1:0]        slot_q [NUM_CH];
  logic [NUM_CH-1:0]           pend_q, pend_d, ovr_q, ovr_d, load_oh;
  logic [CH_W-1:0]             ptr_q, sel;
  logic                        found, load;

  function automatic logic [CH_W-1:0] wrap(input int v);
    return CH_W'(v % NUM_CH);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] com_q, com_d, cand_q, cand_d, bus;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 acc;
    assign bus = i_bus[c*BUS_WIDTH +: BUS_WIDTH];
    assign acc_v[c] = acc;
    assign val_v[c*BUS_WIDTH +: BUS_WIDTH] = com_d;
    // Tracker next state: prime, detect change, require a run of identical samples, drop glitches back to committed
    always_comb begin
      state_d = state_q;
      com_d   = com_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      acc     = 1'b0;
      case (state_q)
        PRIME: begin
          state_d = STABLE;
          com_d   = bus;
          cand_d  = bus;
        end
        STABLE: if (bus != com_q) begin
          cand_d = bus;
          cnt_d  = '0;
          if (SETTLE_CYCLES == 0) begin
            com_d = bus;
            acc   = 1'b1;
          end else state_d = SETTLING;
        end
        SETTLING: if (bus != cand_q) begin
          cand_d = bus;
          cnt_d  = '0;
          state_d = (bus == com_q) ? STABLE : SETTLING;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          com_d   = cand_q;
          acc     = 1'b1;
          state_d = STABLE;
        end else cnt_d = cnt_q + 1'b1;
        default: state_d = PRIME;
      endcase
    end
    // Tracker registers; reset sends every channel back through PRIME
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q <= PRIME;
        com_q   <= '0;
        cand_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        com_q   <= com_d;
        cand_q  <= cand_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  // Round-robin pick: first pending slot searching upward from the channel after the last one served
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!found && pend_q[wrap(int'(ptr_q) + k)]) begin
        found = 1'b1;
        sel   = wrap(int'(ptr_q) + k);
      end
    end
  end

  assign load    = (!o_valid || i_ready) && found;
  assign load_oh = load ? (NUM_CH'(1) << sel) : '0;
  // A same-edge write wins over the load's clear so the fresh value stays pending; overrun only when the old value is lost
  assign pend_d  = (pend_q & ~load_oh) | acc_v;
  assign ovr_d   = i_clear_overrun ? '0 : (ovr_q | (acc_v & pend_q & ~load_oh));

  assign o_pending = pend_q;
  assign o_overrun = ovr_q;

  // Event slots, pending/overrun flags and the one-deep output stage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) slot_q[c] <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      ptr_q   <= CH_W'(NUM_CH - 1);
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_value <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) if (acc_v[c]) slot_q[c] <= val_v[c*BUS_WIDTH +: BUS_WIDTH];
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      if (load) begin
        o_valid <= 1'b1;
        o_ch    <= sel;
        o_value <= slot_q[sel];
        ptr_q   <= sel;
      end else if (!o_valid || i_ready) o_valid <= 1'b0;
    end
  end

`ifdef BUS_CHANGE_MONITOR_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] slot_ts_q [NUM_CH];
  // Free-running timestamp, stamped into a slot on each write and carried with the delivered value
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ts_q        <= '0;
      o_timestamp <= '0;
      for (int c = 0; c < NUM_CH; c++) slot_ts_q[c] <= '0;
    end else begin
      ts_q <= ts_q + 16'd1;
      for (int c = 0; c < NUM_CH; c++) if (acc_v[c]) slot_ts_q[c] <= ts_q;
      if (load) o_timestamp <= slot_ts_q[sel];
    end
  end
`endif
endmodule
